// File: rtl/connect_fifo_n.sv
// Say/heard connector with a DEPTH-entry circular FIFO between the request
// source and the indication sink, plus occupancy and a wrapping delivery count.
module connect_fifo_n #(
   parameter int WIDTH     = 192,
   parameter int DEPTH     = 4,
   parameter int CNT_WIDTH = 11
) (
   input  logic                       CLK,
   input  logic                       nRST,
   input  logic                       say__ENA,
   input  logic [WIDTH-1:0]           say_meth,
   input  logic [WIDTH-1:0]           say_v,
   output logic                       say__RDY,
   output logic                       ind_heard__ENA,
   output logic [WIDTH-1:0]           ind_heard_heard_meth,
   output logic [WIDTH-1:0]           ind_heard_heard_v,
   input  logic                       ind_heard__RDY,
   input  logic                       rule_enable,
   output logic                       rule_ready,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [CNT_WIDTH-1:0]       heard_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = PW + 1;

   logic [2*WIDTH-1:0] mem [DEPTH];
   logic [2*WIDTH-1:0] head;

   logic [PW-1:0]        wr_ptr_reg;
   logic [PW-1:0]        rd_ptr_reg;
   logic [OW-1:0]        occ_reg;
   logic [CNT_WIDTH-1:0] cnt_reg;

   logic say_en;
   logic resp_en;
   logic not_empty;

   assign not_empty = (occ_reg != '0);

   // Gated by nRST so the source sees "not ready" for the whole reset window;
   // the guard looks only at registered occupancy, never at the sink.
   assign say__RDY   = nRST & (occ_reg != OW'(DEPTH));
   assign say_en     = say__ENA & say__RDY;
   assign rule_ready = not_empty & ind_heard__RDY;
   assign resp_en    = rule_enable & rule_ready;

   assign ind_heard__ENA = resp_en;

   assign head                 = mem[rd_ptr_reg];
   assign ind_heard_heard_meth = not_empty ? head[2*WIDTH-1:WIDTH] : '0;
   assign ind_heard_heard_v    = not_empty ? head[WIDTH-1:0]       : '0;

   assign occupancy   = occ_reg;
   assign heard_count = cnt_reg;

   // Payload storage carries no reset so it can map onto plain RAM.
   always_ff @(posedge CLK) begin
      if (say_en) begin
         mem[wr_ptr_reg] <= {say_meth, say_v};
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         occ_reg    <= '0;
         cnt_reg    <= '0;
      end else begin
         if (say_en) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (resp_en) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
            cnt_reg    <= cnt_reg + CNT_WIDTH'(1);
         end
         case ({say_en, resp_en})
            2'b10:   occ_reg <= occ_reg + OW'(1);
            2'b01:   occ_reg <= occ_reg - OW'(1);
            default: occ_reg <= occ_reg;
         endcase
      end
   end

endmodule
